// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC + imem issue + DEPTH-entry prefetch queue; head valid 2 cycles after issue, 1 instr/cycle.
// Backpressure: instr_ready low stalls issue once count+inflight reaches DEPTH. `FETCH_STATS_EN adds stat counters.
module fetch_queue_unit #(
    parameter int PC_W     = 8,
    parameter int INSTR_W  = 16,
    parameter int DEPTH    = 4,
    parameter int RESET_PC = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    output logic               imem_rd_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               branch_i,
    input  logic [PC_W-1:0]    branch_target_i,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    instr_pc_o,
    output logic [3:0]         opcode_o
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]        stat_fetched,
    output logic [15:0]        stat_killed
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_REDIRECT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] ret_pc_q, ret_pc_d;
    logic            inflight_q, inflight_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [INSTR_W-1:0] instr_mem_q [DEPTH];
    logic [PC_W-1:0]    pc_mem_q    [DEPTH];

    logic issue;
    logic push;
    logic pop;

    // Space is reserved for the in-flight word, so a full queue can never be overrun.
    assign issue = (state_q != ST_BOOT) && enable && !branch_i
                   && ((int'(count_q) + int'(inflight_q)) < DEPTH);
    assign push  = inflight_q && !branch_i;
    assign pop   = instr_valid && instr_ready;

    assign imem_rd_en  = issue;
    assign imem_addr   = issue ? pc_q : '0;
    assign instr_valid = (count_q != '0);
    assign instr_o     = instr_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign instr_pc_o  = instr_valid ? pc_mem_q[rd_ptr_q] : '0;
    assign opcode_o    = instr_o[INSTR_W-1 -: 4];

    always_comb begin
        state_d    = ST_RUN;
        pc_d       = pc_q;
        ret_pc_d   = issue ? pc_q : ret_pc_q;
        inflight_d = issue;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (branch_i) begin
            state_d  = ST_REDIRECT;
            pc_d     = branch_target_i;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (issue) pc_d = pc_q + PC_W'(1);
            if (push)  wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= PC_W'(RESET_PC);
            ret_pc_q   <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ret_pc_q   <= ret_pc_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= ret_pc_q;
        end
    end

`ifdef FETCH_STATS_EN
    logic [15:0] stat_fetched_q, stat_fetched_d;
    logic [15:0] stat_killed_q, stat_killed_d;
    logic [16:0] fetched_sum;
    logic [16:0] killed_sum;

    // A head popped in the branch cycle was consumed, so it is not counted as killed.
    always_comb begin
        fetched_sum = {1'b0, stat_fetched_q} + 17'(push);
        killed_sum  = {1'b0, stat_killed_q};
        if (branch_i) begin
            killed_sum = {1'b0, stat_killed_q} + 17'(count_q) + 17'(inflight_q) - 17'(pop);
        end
        stat_fetched_d = fetched_sum[16] ? 16'hFFFF : fetched_sum[15:0];
        stat_killed_d  = killed_sum[16]  ? 16'hFFFF : killed_sum[15:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_fetched_q <= '0;
            stat_killed_q  <= '0;
        end else begin
            stat_fetched_q <= stat_fetched_d;
            stat_killed_q  <= stat_killed_d;
        end
    end

    assign stat_fetched = stat_fetched_q;
    assign stat_killed  = stat_killed_q;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: memory word[a] = 0x1000 + a; expected PCs queued on reset/redirect, popped on handshake.
module tb_fetch_queue_unit;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        imem_rd_en;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        branch_i;
    logic [7:0]  branch_target_i;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_o;
    logic [7:0]  instr_pc_o;
    logic [3:0]  opcode_o;
`ifdef FETCH_STATS_EN
    logic [15:0] stat_fetched;
    logic [15:0] stat_killed;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_issue = 0;
    int n_pop   = 0;
    logic [7:0] sb [$];

    fetch_queue_unit dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .imem_rd_en      (imem_rd_en),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .opcode_o        (opcode_o)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched    (stat_fetched),
        .stat_killed     (stat_killed)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory; garbage when not read so stray pushes are visible.
    always @(posedge clk) begin
        imem_rdata <= imem_rd_en ? (16'h1000 + {8'h00, imem_addr}) : 16'hDEAD;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_load(input logic [7:0] start);
        logic [7:0] p;
        sb.delete();
        for (int i = 0; i < 128; i++) begin
            p = start + 8'(i);
            sb.push_back(p);
        end
    endtask

    // Evaluate the current interval (pop against the scoreboard) then advance one clock.
    task automatic cyc();
        logic [7:0]  e;
        logic [15:0] ew;
        #1;
        if (imem_rd_en) n_issue++;
        if (instr_valid && instr_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e  = sb.pop_front();
                ew = 16'h1000 + {8'h00, e};
                chk("head_pc", {24'd0, instr_pc_o}, {24'd0, e});
                chk("head_instr", {16'd0, instr_o}, {16'd0, ew});
                chk("head_opcode", {28'd0, opcode_o}, {28'd0, ew[15:12]});
                n_pop++;
            end
        end else if (!instr_valid) begin
            chk("idle_opcode", {28'd0, opcode_o}, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset           = 1'b0;
        enable          = 1'b0;
        branch_i        = 1'b0;
        branch_target_i = 8'h00;
        instr_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_rd_en", {31'd0, imem_rd_en}, 32'd0);
        reset = 1'b1;
        sb_load(8'h00);
        n_issue = 0;
    endtask

    initial begin
        int p0;
        int i0;
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
        p0 = 0; i0 = 0;
    end

    initial begin
        int p0;
        int i0;

        // Startup latency and first stream
        do_reset();
        enable = 1'b1; instr_ready = 1'b1;
        #1 chk("boot_no_issue", {31'd0, imem_rd_en}, 32'd0);
        cyc();
        #1 chk("first_issue", {31'd0, imem_rd_en}, 32'd1);
        chk("first_addr", {24'd0, imem_addr}, 32'h0);
        cyc();
        #1 chk("c2_not_valid", {31'd0, instr_valid}, 32'd0);
        cyc();
        #1 chk("c3_valid", {31'd0, instr_valid}, 32'd1);
        chk("c3_instr", {16'd0, instr_o}, 32'h1000);
        chk("c3_pc", {24'd0, instr_pc_o}, 32'h0);
        cyc();
        repeat (5) begin
            #1 chk("stream_valid", {31'd0, instr_valid}, 32'd1);
            cyc();
        end

        // Backpressure: queue fills, exactly DEPTH issues
        do_reset();
        enable = 1'b1; instr_ready = 1'b0;
        repeat (12) cyc();
        chk("stall_issues", n_issue, 32'd4);
        #1 chk("stall_valid", {31'd0, instr_valid}, 32'd1);
        chk("stall_head", {16'd0, instr_o}, 32'h1000);
        instr_ready = 1'b1;
        p0 = n_pop;
        repeat (8) begin
            #1 chk("drain_valid", {31'd0, instr_valid}, 32'd1);
            cyc();
        end
        chk("drain_pops", n_pop - p0, 32'd8);

        // Redirect with 3 queued and 1 in flight
        do_reset();
        enable = 1'b1; instr_ready = 1'b0;
        repeat (5) cyc();
        branch_i = 1'b1; branch_target_i = 8'h40;
        #1 chk("branch_no_issue", {31'd0, imem_rd_en}, 32'd0);
        cyc();
        sb_load(8'h40);
        branch_i = 1'b0; instr_ready = 1'b1;
        #1 chk("redir_issue", {31'd0, imem_rd_en}, 32'd1);
        chk("redir_addr", {24'd0, imem_addr}, 32'h40);
        chk("redir_flushed", {31'd0, instr_valid}, 32'd0);
`ifdef FETCH_STATS_EN
        chk("stat_killed", {16'd0, stat_killed}, 32'd4);
        chk("stat_fetched", {16'd0, stat_fetched}, 32'd3);
`endif
        cyc();
        #1 chk("redir_wait", {31'd0, instr_valid}, 32'd0);
        cyc();
        #1 chk("redir_head_valid", {31'd0, instr_valid}, 32'd1);
        chk("redir_head", {16'd0, instr_o}, 32'h1040);
        chk("redir_head_pc", {24'd0, instr_pc_o}, 32'h40);
        repeat (4) cyc();

        // PC wrap through a redirect taken while streaming
        branch_i = 1'b1; branch_target_i = 8'hFE;
        cyc();
        sb_load(8'hFE);
        branch_i = 1'b0;
        p0 = n_pop;
        repeat (8) cyc();
        chk("wrap_pops", n_pop - p0, 32'd6);

        // enable dropped with a read in flight
        #1 chk("pre_disable_issue", {31'd0, imem_rd_en}, 32'd1);
        enable = 1'b0;
        i0 = n_issue;
        repeat (6) cyc();
        chk("disabled_issues", n_issue - i0, 32'd0);
        #1 chk("drained", {31'd0, instr_valid}, 32'd0);
        enable = 1'b1;
        #1 chk("reenable_issue", {31'd0, imem_rd_en}, 32'd1);
        chk("reenable_addr", {24'd0, imem_addr}, {24'd0, sb[0]});
        repeat (4) cyc();

        // Asynchronous reset mid-stream
        #1 chk("pre_reset_valid", {31'd0, instr_valid}, 32'd1);
        reset = 1'b0;
        #1 chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_rd_en", {31'd0, imem_rd_en}, 32'd0);
        chk("arst_addr", {24'd0, imem_addr}, 32'd0);
        chk("arst_instr", {16'd0, instr_o}, 32'd0);
        chk("arst_pc", {24'd0, instr_pc_o}, 32'd0);
        chk("arst_opcode", {28'd0, opcode_o}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        sb_load(8'h00);
        #1 chk("reboot_no_issue", {31'd0, imem_rd_en}, 32'd0);
        cyc();
        #1 chk("reboot_issue", {31'd0, imem_rd_en}, 32'd1);
        chk("reboot_addr", {24'd0, imem_addr}, 32'h0);
        cyc();
        cyc();
        #1 chk("reboot_head", {16'd0, instr_o}, 32'h1000);
        repeat (3) cyc();

        // Redirect while still in BOOT
        do_reset();
        enable = 1'b1; instr_ready = 1'b1;
        branch_i = 1'b1; branch_target_i = 8'h80;
        cyc();
        sb_load(8'h80);
        branch_i = 1'b0;
        #1 chk("boot_redir_issue", {31'd0, imem_rd_en}, 32'd1);
        chk("boot_redir_addr", {24'd0, imem_addr}, 32'h80);
        repeat (5) cyc();
        chk("boot_redir_head", {24'd0, instr_pc_o}, 32'h83);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
